// File: rtl/scan_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : scan_pkg                                                    |
// | Description : Shared types and defaults for the scan chain controller.    |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package scan_pkg;

    localparam int c_chain_len_default = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_UNLOAD  = 2'd3
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/scan_chain_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : scan_chain_ctrl_if                                          |
// | Description : Pattern-in / response-out handshake of the scan controller. |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
interface scan_chain_ctrl_if
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = c_chain_len_default
) ();

    logic                 pat_valid;
    logic [CHAIN_LEN-1:0] pat_in;
    logic                 pat_ready;
    logic                 resp_valid;
    logic [CHAIN_LEN-1:0] resp_out;

    modport master (
        output pat_valid,
        output pat_in,
        input  pat_ready,
        input  resp_valid,
        input  resp_out
    );

    modport slave (
        input  pat_valid,
        input  pat_in,
        output pat_ready,
        output resp_valid,
        output resp_out
    );

endinterface
`default_nettype wire

// File: rtl/scan_shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : scan_shift_reg                                              |
// | Description : Parallel-load shift register, MSB-first out, serial-in LSB. |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module scan_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_shift,
    input  logic             i_ser_in,
    output logic             o_ser_out,
    output logic [WIDTH-1:0] o_q_shifted
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_shifted;

    assign w_q_shifted = {r_q[WIDTH-2:0], i_ser_in};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift) begin
            r_q <= w_q_shifted;
        end
    end

    assign o_ser_out   = r_q[WIDTH-1];
    // Post-shift view lets the controller register a response on the final edge.
    assign o_q_shifted = w_q_shifted;

endmodule
`default_nettype wire

// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : scan_chain_ctrl                                             |
// | Description : Load / capture / unload sequencer for one scan chain.       |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = c_chain_len_default
) (
    input  logic             C,
    input  logic             RN,
    scan_chain_ctrl_if.slave bus,
    output logic             SE,
    output logic             SI,
    input  logic             SO,
    output logic             busy
);

    localparam int                  c_cnt_w    = $clog2(CHAIN_LEN + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(CHAIN_LEN - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

    scan_state_t          r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_pend;
    logic                 r_se;
    logic                 r_busy;
    logic                 r_ready;
    logic                 r_resp_valid;
    logic [CHAIN_LEN-1:0] r_resp;

    logic                 w_pat_ready;
    logic                 w_xfer;
    logic                 w_last;
    logic                 w_sr_load;
    logic                 w_sr_shift;
    logic                 w_sr_clear;
    logic [CHAIN_LEN-1:0] w_sr_data;
    logic [CHAIN_LEN-1:0] w_sr_next;
    logic                 w_sr_out;

    // Ready is gated by RN so no pattern can be taken while reset is asserted.
    assign w_pat_ready = r_ready & RN;
    assign w_xfer      = bus.pat_valid & w_pat_ready;
    assign w_last      = (r_cnt == c_cnt_last);

    always_comb begin
        w_sr_load  = 1'b0;
        w_sr_shift = 1'b0;
        w_sr_clear = 1'b0;
        w_sr_data  = bus.pat_in;
        case (r_state)
            ST_IDLE: begin
                w_sr_load = w_xfer;
            end
            ST_LOAD: begin
                w_sr_shift = 1'b1;
            end
            ST_CAPTURE: begin
                // Without a new pattern the unload shifts zeros into the chain.
                w_sr_load = 1'b1;
                w_sr_data = w_xfer ? bus.pat_in : '0;
            end
            ST_UNLOAD: begin
                w_sr_shift = 1'b1;
                w_sr_clear = w_last;
            end
            default: begin
                w_sr_load = 1'b0;
            end
        endcase
    end

    scan_shift_reg #(
        .WIDTH (CHAIN_LEN)
    ) u_shift_reg (
        .clk         (C),
        .rst_n       (RN),
        .i_clear     (w_sr_clear),
        .i_load      (w_sr_load),
        .i_data      (w_sr_data),
        .i_shift     (w_sr_shift),
        .i_ser_in    (SO),
        .o_ser_out   (w_sr_out),
        .o_q_shifted (w_sr_next)
    );

    always_ff @(posedge C) begin
        if (!RN) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_pend       <= 1'b0;
            r_se         <= 1'b0;
            r_busy       <= 1'b0;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp       <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_state <= ST_LOAD;
                        r_se    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_last) begin
                        r_state <= ST_CAPTURE;
                        r_cnt   <= '0;
                        r_se    <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_UNLOAD;
                    r_pend  <= w_xfer;
                    r_se    <= 1'b1;
                    r_ready <= 1'b0;
                end
                ST_UNLOAD: begin
                    if (w_last) begin
                        r_cnt        <= '0;
                        r_pend       <= 1'b0;
                        r_se         <= 1'b0;
                        r_ready      <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_resp       <= w_sr_next;
                        if (r_pend) begin
                            r_state <= ST_CAPTURE;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign SE             = r_se;
    assign SI             = w_sr_out;
    assign busy           = r_busy;
    assign bus.pat_ready  = w_pat_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_out   = r_resp;

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_scan_chain_ctrl                                          |
// | Description : Self-checking bench with a 4-cell scan chain model.        |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_scan_chain_ctrl;

    localparam int N = 4;

    logic         C     = 1'b0;
    logic         RN    = 1'b0;
    logic         SE;
    logic         SI;
    logic         SO;
    logic         busy;
    logic [N-1:0] chain = '0;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int xfer_cnt = 0;
    int rv_cnt   = 0;

    logic [N-1:0] exp_q[$];

    scan_chain_ctrl_if #(.CHAIN_LEN(N)) bus ();

    scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
        .C    (C),
        .RN   (RN),
        .bus  (bus),
        .SE   (SE),
        .SI   (SI),
        .SO   (SO),
        .busy (busy)
    );

    always #5 C = ~C;

    // Functional D input of cell i is (i parity) XOR 1.
    function automatic logic [N-1:0] capture_value();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = ~i[0];
        return v;
    endfunction

    // DFFS1 scan cells: shift SI->cell0->...->cell N-1 when SE, else capture D.
    always @(posedge C) begin
        cyc <= cyc + 1;
        if (bus.pat_valid && bus.pat_ready) xfer_cnt <= xfer_cnt + 1;
        if (SE) chain <= {chain[N-2:0], SI};
        else    chain <= capture_value();
    end
    assign SO = chain[N-1];

    always @(negedge C) begin
        if (bus.resp_valid) rv_cnt <= rv_cnt + 1;
    end

    task automatic send_pattern(input logic [N-1:0] p, output int acc, output bit ok);
        ok  = 1'b0;
        acc = 0;
        bus.pat_valid = 1'b1;
        bus.pat_in    = p;
        for (int t = 0; t < 50; t++) begin
            if (bus.pat_ready) begin
                acc = cyc + 1;
                ok  = 1'b1;
                exp_q.push_back(capture_value());
                @(negedge C);
                break;
            end
            @(negedge C);
        end
        bus.pat_valid = 1'b0;
    endtask

    task automatic wait_resp(output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int t = 0; t < 50; t++) begin
            if (bus.resp_valid) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            @(negedge C);
        end
    endtask

    task automatic test_reset();
        int x0;
        RN = 1'b0;
        bus.pat_valid = 1'b1;
        bus.pat_in    = 4'b1111;
        repeat (3) @(negedge C);
        checks++; if (bus.pat_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", bus.pat_ready); end
        checks++; if (SE !== 1'b0) begin errors++; $display("FAIL rst_se: got %b expected 0", SE); end
        checks++; if (SI !== 1'b0) begin errors++; $display("FAIL rst_si: got %b expected 0", SI); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b expected 0", bus.resp_valid); end
        checks++; if (bus.resp_out !== 4'b0000) begin errors++; $display("FAIL rst_resp: got %b expected 0000", bus.resp_out); end
        bus.pat_valid = 1'b0;
        RN = 1'b1;
        x0 = xfer_cnt;
        for (int k = 0; k < 3; k++) begin
            @(negedge C);
            checks++; if (SE !== 1'b0 || busy !== 1'b0 || bus.pat_ready !== 1'b1) begin
                errors++; $display("FAIL idle_hold: se=%b busy=%b ready=%b expected 0 0 1", SE, busy, bus.pat_ready);
            end
        end
        checks++; if (xfer_cnt !== x0) begin errors++; $display("FAIL idle_xfer: got %0d transfers expected 0", xfer_cnt - x0); end
    endtask

    task automatic test_load();
        logic [N-1:0] p;
        logic [N-1:0] e;
        int acc;
        int at;
        bit ok;
        p = 4'b1011;
        send_pattern(p, acc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL load_accept: got no transfer expected one"); end
        for (int k = 0; k < N; k++) begin
            checks++; if (SE !== 1'b1) begin errors++; $display("FAIL load_se[%0d]: got %b expected 1", k, SE); end
            checks++; if (SI !== p[N-1-k]) begin errors++; $display("FAIL load_si[%0d]: got %b expected %b", k, SI, p[N-1-k]); end
            @(negedge C);
        end
        checks++; if (chain !== p) begin errors++; $display("FAIL load_chain: got %b expected %b", chain, p); end
        checks++; if (SE !== 1'b0) begin errors++; $display("FAIL load_capture_se: got %b expected 0", SE); end
        wait_resp(at, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL load_resp: got timeout expected resp_valid");
        end else if (exp_q.size() == 0) begin
            errors++; $display("FAIL load_resp: got %b with empty scoreboard", bus.resp_out);
        end else begin
            e = exp_q.pop_front();
            if (bus.resp_out !== e) begin errors++; $display("FAIL load_resp: got %b expected %b", bus.resp_out, e); end
        end
        @(negedge C);
    endtask

    task automatic test_single();
        logic [N-1:0] e;
        int acc;
        int at;
        int se0;
        bit ok;
        bit seen;
        se0  = 0;
        seen = 1'b0;
        send_pattern(4'b0110, acc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_accept: got no transfer expected one"); end
        for (int t = 0; t < 40; t++) begin
            if (bus.resp_valid) begin seen = 1'b1; break; end
            if (SE === 1'b0) se0++;
            @(negedge C);
        end
        at = cyc;
        checks++; if (se0 != 1) begin errors++; $display("FAIL single_capture_len: got %0d cycles expected 1", se0); end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL single_resp: got timeout expected resp_valid");
        end else begin
            if (at - acc != 2 * N + 1) begin errors++; $display("FAIL single_latency: got %0d expected %0d", at - acc, 2 * N + 1); end
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL single_resp: got %b with empty scoreboard", bus.resp_out);
            end else begin
                e = exp_q.pop_front();
                if (bus.resp_out !== e) begin errors++; $display("FAIL single_resp: got %b expected %b", bus.resp_out, e); end
            end
        end
        checks++; if (busy !== 1'b0 || SE !== 1'b0 || bus.pat_ready !== 1'b1) begin
            errors++; $display("FAIL single_idle: busy=%b se=%b ready=%b expected 0 0 1", busy, SE, bus.pat_ready);
        end
        @(negedge C);
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b expected 0", bus.resp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] b;
        logic [N-1:0] e;
        int acc1;
        int acc2;
        int at1;
        int at2;
        bit ok;
        b = 4'b1100;
        send_pattern(4'b0011, acc1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_accept1: got no transfer expected one"); end
        repeat (N) @(negedge C);
        checks++; if (bus.pat_ready !== 1'b1 || SE !== 1'b0) begin
            errors++; $display("FAIL b2b_capture: ready=%b se=%b expected 1 0", bus.pat_ready, SE);
        end
        send_pattern(b, acc2, ok);
        checks++; if (!ok || acc2 != acc1 + N + 1) begin errors++; $display("FAIL b2b_accept2: got cycle %0d expected %0d", acc2 - acc1, N + 1); end
        for (int k = 0; k < N; k++) begin
            checks++; if (SE !== 1'b1 || SI !== b[N-1-k]) begin
                errors++; $display("FAIL b2b_unload_si[%0d]: se=%b si=%b expected 1 %b", k, SE, SI, b[N-1-k]);
            end
            @(negedge C);
        end
        wait_resp(at1, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_resp1: got timeout expected resp_valid");
        end else if (exp_q.size() == 0) begin
            errors++; $display("FAIL b2b_resp1: got %b with empty scoreboard", bus.resp_out);
        end else begin
            e = exp_q.pop_front();
            if (bus.resp_out !== e) begin errors++; $display("FAIL b2b_resp1: got %b expected %b", bus.resp_out, e); end
        end
        checks++; if (SE !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_direct_capture: se=%b busy=%b expected 0 1", SE, busy); end
        checks++; if (chain !== b) begin errors++; $display("FAIL b2b_chain: got %b expected %b", chain, b); end
        @(negedge C);
        wait_resp(at2, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_resp2: got timeout expected resp_valid");
        end else if (exp_q.size() == 0) begin
            errors++; $display("FAIL b2b_resp2: got %b with empty scoreboard", bus.resp_out);
        end else begin
            e = exp_q.pop_front();
            if (bus.resp_out !== e) begin errors++; $display("FAIL b2b_resp2: got %b expected %b", bus.resp_out, e); end
        end
        checks++; if (at2 - at1 != N + 1) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", at2 - at1, N + 1); end
        @(negedge C);
    endtask

    task automatic test_reset_abort();
        int acc;
        int rv0;
        bit ok;
        send_pattern(4'b1001, acc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_accept: got no transfer expected one"); end
        repeat (N + 3) @(negedge C);
        RN  = 1'b0;
        exp_q.delete();
        rv0 = rv_cnt;
        @(negedge C);
        checks++; if (SE !== 1'b0 || busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL abort_state: se=%b busy=%b rvalid=%b expected 0 0 0", SE, busy, bus.resp_valid);
        end
        checks++; if (bus.pat_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", bus.pat_ready); end
        RN = 1'b1;
        repeat (3 * N) @(negedge C);
        checks++; if (rv_cnt !== rv0) begin errors++; $display("FAIL abort_no_resp: got %0d pulses expected 0", rv_cnt - rv0); end
        checks++; if (busy !== 1'b0 || bus.resp_out !== 4'b0000) begin
            errors++; $display("FAIL abort_idle: busy=%b resp=%b expected 0 0000", busy, bus.resp_out);
        end
    endtask

    task automatic test_valid_hold();
        logic [N-1:0] e;
        int x0;
        int acc;
        int at;
        bit ok;
        x0  = xfer_cnt;
        bus.pat_valid = 1'b1;
        bus.pat_in    = 4'b1010;
        acc = cyc + 1;
        exp_q.push_back(capture_value());
        for (int k = 0; k < N; k++) begin
            @(negedge C);
            checks++; if (bus.pat_ready !== 1'b0 || SE !== 1'b1) begin
                errors++; $display("FAIL hold_load[%0d]: ready=%b se=%b expected 0 1", k, bus.pat_ready, SE);
            end
        end
        @(negedge C);
        bus.pat_valid = 1'b0;
        wait_resp(at, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL hold_resp: got timeout expected resp_valid");
        end else begin
            if (at - acc != 2 * N + 1) begin errors++; $display("FAIL hold_latency: got %0d expected %0d", at - acc, 2 * N + 1); end
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL hold_resp: got %b with empty scoreboard", bus.resp_out);
            end else begin
                e = exp_q.pop_front();
                if (bus.resp_out !== e) begin errors++; $display("FAIL hold_resp: got %b expected %b", bus.resp_out, e); end
            end
        end
        checks++; if (xfer_cnt - x0 != 1) begin errors++; $display("FAIL hold_xfer_count: got %0d expected 1", xfer_cnt - x0); end
        @(negedge C);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d leftover expected 0", exp_q.size()); end
    endtask

    initial begin
        bus.pat_valid = 1'b0;
        bus.pat_in    = '0;
        test_reset();
        test_load();
        test_single();
        test_back_to_back();
        test_reset_abort();
        test_valid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 8, meaning the number of scan cells in the driven chain (legal 2..64).
REQ-002 SHALL have port C, input, 1, the single clock; the controller and the chain both sample on its rising edge.
REQ-003 SHALL have port RN, input, 1, the reset; it is synchronous and active-low.
REQ-004 SHALL have port pat_valid, input, 1, meaning a test pattern is offered.
REQ-005 SHALL have port pat_in, input, CHAIN_LEN, the pattern; bit i is destined for chain cell i.
REQ-006 SHALL have port pat_ready, output, 1, meaning the controller accepts a pattern this cycle.
REQ-007 SHALL have port SE, output, 1, the scan enable driven to every cell (1 = shift, 0 = capture).
REQ-008 SHALL have port SI, output, 1, the serial data into cell 0.
REQ-009 SHALL have port SO, input, 1, the Q output of cell CHAIN_LEN-1.
REQ-010 SHALL have port resp_valid, output, 1, a one-cycle pulse when a response is complete.
REQ-011 SHALL have port resp_out, output, CHAIN_LEN, the captured response; bit i is the value captured in cell i.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement the states IDLE, LOAD, CAPTURE and UNLOAD.
REQ-014 SHALL drive SE=1 in LOAD and UNLOAD, and SE=0 in IDLE and CAPTURE; SE is a function of the state only.
REQ-015 SHALL assert pat_ready in IDLE and in CAPTURE only; a transfer occurs when pat_valid and pat_ready are high at a rising edge.
REQ-016 SHALL, on a transfer in IDLE, load the shift register with pat_in and enter LOAD.
REQ-017 SHALL stay in LOAD for exactly CHAIN_LEN cycles, presenting SI = pat bit CHAIN_LEN-1 first, down to bit 0 last, then enter CAPTURE.
REQ-018 SHALL stay in CAPTURE for exactly one cycle, then enter UNLOAD.
REQ-019 SHALL stay in UNLOAD for exactly CHAIN_LEN cycles, sampling SO in each cycle before its rising edge; the first sample lands in resp bit CHAIN_LEN-1 and the last in resp bit 0.
REQ-020 SHALL, during UNLOAD, drive SI with the pattern accepted in CAPTURE (MSB first) if there was one, and with 0 otherwise.
REQ-021 SHALL, at the end of UNLOAD, enter CAPTURE if a pattern was accepted during the preceding CAPTURE; otherwise it SHALL enter IDLE.
REQ-022 SHALL register resp_out and pulse resp_valid for one cycle on the clock edge that completes the final UNLOAD shift.
REQ-023 SHALL hold resp_out stable until the next resp_valid.
REQ-024 SHALL use a shift counter of width clog2(CHAIN_LEN+1) that counts 0..CHAIN_LEN-1 and wraps to 0 on each state exit.
REQ-025 SHALL, when no transfer occurs in IDLE, remain in IDLE with SE=0 while the chain captures functional data.
REQ-026 SHALL, if pat_valid is high in LOAD or UNLOAD, ignore it (pat_ready=0) and not change state.
REQ-027 SHALL guarantee that the minimum pattern-to-response latency is 2*CHAIN_LEN+1 cycles after acceptance; back-to-back throughput is 1 pattern per CHAIN_LEN+1 cycles.

Reset
REQ-028 SHALL, when RN=0 at a rising edge, enter IDLE and set SE=0, SI=0, resp_valid=0, resp_out=0, busy=0, counter=0 and shift register=0.
REQ-029 SHALL abort an operation on reset in any state; no resp_valid for the aborted pattern is ever produced.
REQ-030 SHALL hold pat_ready=0 while RN=0.

Structure
REQ-031 SHALL place the state enum and the CHAIN_LEN default in a shared package scan_pkg.
REQ-032 SHALL implement the serial datapath in one sub-module, scan_shift_reg, with parallel load, MSB-first serial out and serial-in to the LSB; a single instance serves both load and unload.

Verification
REQ-033 The bench SHALL model the chain as CHAIN_LEN team DFFS1 cells on C, with CHAIN_LEN=4 and each cell D = its index parity XOR 1.
REQ-034 Scenario: pat_in=4'b1011 in IDLE -> SE=1 for 4 cycles with SI sequence 1,0,1,1; after LOAD the chain holds 1011.
REQ-035 Scenario: single pattern -> SE=0 for exactly one cycle; resp_out=4'b0101 with resp_valid pulsed 9 cycles after acceptance; return to IDLE.
REQ-036 Scenario: second pattern 4'b1100 offered during CAPTURE -> accepted; UNLOAD shifts SI 1,1,0,0; CAPTURE follows directly; two resp_valid pulses spaced 5 cycles apart.
REQ-037 Scenario: RN=0 in the third UNLOAD cycle -> next cycle IDLE, SE=0, busy=0, no resp_valid.
REQ-038 Scenario: pat_valid held high through LOAD -> pat_ready=0; exactly one transfer counted.
